// File: rtl/monitor_cmd_master.sv
// monitor_cmd_master
// Host-side initiator for the monitor UART command protocol. It requests the
// line with RTS, waits for CTS, sends the command byte {cmd_rw, cmd_id} and the
// size byte, then either sends the write payload or collects the read payload.
// Every abort and every normal end passes through FINISH, which releases RTS
// and pulses done.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               one-cycle command request, taken only while idle
//   cmd_rw, cmd_id      command byte fields (1 = write, 0 = read)
//   data_size           payload byte count
//   wr_data / rd_data   payload buffers, byte k at [8k+:8]
//   busy, done, error   status; error/err_code qualify the done pulse
//   err_code            0 none, 1 bad size, 2 CTS timeout, 3 RX timeout/error
//   uart_rts, uart_cts  active-low handshake
//   tx_write, tx_byte   one-cycle load strobe and byte for uart_tx
//   tx_busy, tx_done    uart_tx status
//   rx_byte, rx_done    received byte and its strobe from uart_rx
//   rx_error            uart_rx framing/parity error strobe
module monitor_cmd_master #(
    parameter int MAX_PAYLOAD_BYTES = 16,
    parameter int CTS_TIMEOUT       = 50000,
    parameter int RX_TIMEOUT        = 500000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           cmd_rw,
    input  logic [6:0]                     cmd_id,
    input  logic [7:0]                     data_size,
    input  logic [8*MAX_PAYLOAD_BYTES-1:0] wr_data,
    output logic [8*MAX_PAYLOAD_BYTES-1:0] rd_data,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [1:0]                     err_code,
    output logic                           uart_rts,
    input  logic                           uart_cts,
    output logic                           tx_write,
    output logic [7:0]                     tx_byte,
    input  logic                           tx_busy,
    input  logic                           tx_done,
    input  logic [7:0]                     rx_byte,
    input  logic                           rx_done,
    input  logic                           rx_error
);
    localparam int PW    = 8 * MAX_PAYLOAD_BYTES;
    localparam int IDX_W = $clog2(MAX_PAYLOAD_BYTES + 1);
    localparam int CTS_W = $clog2(CTS_TIMEOUT + 1);
    localparam int RX_W  = $clog2(RX_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, REQ, SEND_CMD, SEND_SIZE, SEND_DATA, RECV_DATA, FINISH
    } state_t;

    state_t state, state_nx;

    logic             rw_q;
    logic [6:0]       id_q;
    logic [7:0]       size_q;
    logic [PW-1:0]    wr_sh;     // write payload, shifted so the next byte sits in [7:0]
    logic [IDX_W-1:0] idx;
    logic [CTS_W-1:0] cts_cnt;
    logic [RX_W-1:0]  rx_cnt;
    logic             tx_wait;   // byte handed to uart_tx, its tx_done still pending

    logic       size_ok, last_byte;
    logic       accept, reject, issue, tx_ack, rx_take, abort, fin;
    logic [1:0] abort_code;
    logic [7:0] send_byte;

    assign size_ok   = data_size <= 8'(MAX_PAYLOAD_BYTES);
    assign last_byte = (8'(idx) + 8'd1) == size_q;
    assign fin       = (state_nx == FINISH) && (state != FINISH);

    always_comb begin
        send_byte = wr_sh[7:0];
        if (state == SEND_CMD)       send_byte = {rw_q, id_q};
        else if (state == SEND_SIZE) send_byte = size_q;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        reject     = 1'b0;
        issue      = 1'b0;
        tx_ack     = 1'b0;
        rx_take    = 1'b0;
        abort      = 1'b0;
        abort_code = 2'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (size_ok) begin
                        accept   = 1'b1;
                        state_nx = REQ;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            REQ: begin
                if (!uart_cts) begin
                    state_nx = SEND_CMD;
                end else if (cts_cnt == CTS_W'(CTS_TIMEOUT - 1)) begin
                    abort      = 1'b1;
                    abort_code = 2'd2;
                    state_nx   = FINISH;
                end
            end
            SEND_CMD, SEND_SIZE, SEND_DATA: begin
                // tx_done only counts while a byte is outstanding
                if (!tx_wait) begin
                    issue = !tx_busy;
                end else if (tx_done) begin
                    tx_ack = 1'b1;
                    case (state)
                        SEND_CMD:  state_nx = SEND_SIZE;
                        SEND_SIZE: begin
                            if (size_q == 8'd0) state_nx = FINISH;
                            else if (rw_q)      state_nx = SEND_DATA;
                            else                state_nx = RECV_DATA;
                        end
                        default:   if (last_byte) state_nx = FINISH;
                    endcase
                end
            end
            RECV_DATA: begin
                // rx_error takes priority over a coincident rx_done
                if (rx_error) begin
                    abort      = 1'b1;
                    abort_code = 2'd3;
                    state_nx   = FINISH;
                end else if (rx_done) begin
                    rx_take = 1'b1;
                    if (last_byte) state_nx = FINISH;
                end else if (rx_cnt == RX_W'(RX_TIMEOUT - 1)) begin
                    abort      = 1'b1;
                    abort_code = 2'd3;
                    state_nx   = FINISH;
                end
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rw_q     <= 1'b0;
            id_q     <= '0;
            size_q   <= '0;
            wr_sh    <= '0;
            idx      <= '0;
            cts_cnt  <= '0;
            rx_cnt   <= '0;
            tx_wait  <= 1'b0;
            rd_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= 2'd0;
            uart_rts <= 1'b1;
            tx_write <= 1'b0;
            tx_byte  <= '0;
        end else begin
            tx_write <= 1'b0;
            done     <= 1'b0;
            cts_cnt  <= (state == REQ) ? cts_cnt + 1'b1 : '0;
            rx_cnt   <= (state == RECV_DATA && !rx_done) ? rx_cnt + 1'b1 : '0;

            if (accept) begin
                rw_q     <= cmd_rw;
                id_q     <= cmd_id;
                size_q   <= data_size;
                wr_sh    <= wr_data;
                rd_data  <= '0;
                busy     <= 1'b1;
                uart_rts <= 1'b0;
                error    <= 1'b0;
                err_code <= 2'd0;
            end
            // oversize request: report immediately, never touch the line
            if (reject) begin
                done     <= 1'b1;
                error    <= 1'b1;
                err_code <= 2'd1;
            end
            if (issue) begin
                tx_write <= 1'b1;
                tx_byte  <= send_byte;
                tx_wait  <= 1'b1;
            end
            if (tx_ack) begin
                tx_wait <= 1'b0;
                if (state == SEND_SIZE) begin
                    idx <= '0;
                end else if (state == SEND_DATA) begin
                    idx   <= idx + 1'b1;
                    wr_sh <= wr_sh >> 8;
                end
            end
            if (rx_take) begin
                for (int k = 0; k < MAX_PAYLOAD_BYTES; k++)
                    if (idx == IDX_W'(k)) rd_data[8*k +: 8] <= rx_byte;
                idx <= idx + 1'b1;
            end
            if (fin) begin
                uart_rts <= 1'b1;
                busy     <= 1'b0;
                done     <= 1'b1;
                error    <= abort;
                err_code <= abort_code;
            end
        end
    end

endmodule

// File: tb/tb_monitor_cmd_master.sv
// Bench for monitor_cmd_master: directed test-plan cases pinned with literal
// expectations, then randomized commands checked against a transaction model
// (expected tx byte stream, read payload and result code) by a per-cycle
// compare process.
module tb_monitor_cmd_master;
    localparam int MAX   = 16;
    localparam int CTS_T = 30;
    localparam int RX_T  = 40;
    localparam int PW    = 8 * MAX;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, cmd_rw = 1'b0;
    logic [6:0]    cmd_id = '0;
    logic [7:0]    data_size = '0;
    logic [PW-1:0] wr_data = '0;
    logic [PW-1:0] rd_data;
    logic          busy, done, error, uart_rts, tx_write;
    logic [1:0]    err_code;
    logic [7:0]    tx_byte;
    logic          uart_cts = 1'b1, tx_busy = 1'b0, tx_done = 1'b0;
    logic [7:0]    rx_byte = '0;
    logic          rx_done = 1'b0, rx_error = 1'b0;

    monitor_cmd_master #(
        .MAX_PAYLOAD_BYTES(MAX), .CTS_TIMEOUT(CTS_T), .RX_TIMEOUT(RX_T)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cmd_rw(cmd_rw), .cmd_id(cmd_id),
        .data_size(data_size), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
        .done(done), .error(error), .err_code(err_code), .uart_rts(uart_rts),
        .uart_cts(uart_cts), .tx_write(tx_write), .tx_byte(tx_byte), .tx_busy(tx_busy),
        .tx_done(tx_done), .rx_byte(rx_byte), .rx_done(rx_done), .rx_error(rx_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // model state
    int            n_chk = 0, n_fail = 0;
    logic [7:0]    exp_tx[$];
    logic [PW-1:0] exp_rd = '0;
    int            exp_code = 0;
    bit            done_pending = 0, seen_done = 0, stall_case = 0, outstanding = 0;
    logic          hold_err = 1'b0;
    logic [1:0]    hold_code = 2'd0;
    int            start_cyc = 0, last_rx_cyc = 0, n_txw = 0, n_txdone = 0;
    logic [63:0]   tx_log = '0;
    logic [7:0]    rx_src[MAX];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // uart_tx stand-in: busy for a few cycles per byte, then a tx_done pulse
    initial begin
        int left;
        left = 0;
        forever begin
            @(posedge clk); #1;
            tx_done = 1'b0;
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    tx_busy = 1'b0;
                    tx_done = 1'b1;
                end
            end else if (tx_write) begin
                tx_busy = 1'b1;
                left = int'($urandom_range(2, 5));
            end
        end
    end

    // per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        if (tx_done) begin
            outstanding = 0;
            n_txdone++;
        end
        if (!reset) begin
            chk("rts_tracks_busy", uart_rts, !busy);
            if (tx_write) begin
                chk("single_outstanding", outstanding, 0);
                outstanding = 1;
                n_txw++;
                tx_log = {tx_log[55:0], tx_byte};
                chk("tx_queue_nonempty", exp_tx.size() > 0, 1);
                if (exp_tx.size() > 0) chk("tx_byte", tx_byte, exp_tx.pop_front());
            end
            if (done) begin
                chk("done_expected", done_pending, 1);
                done_pending = 0;
                seen_done = 1;
                chk("error", error, exp_code != 0);
                chk("err_code", err_code, exp_code);
                chk("rd_data", rd_data, exp_rd);
                chk("all_bytes_sent", exp_tx.size(), 0);
                chk("busy_at_done", busy, 0);
                if (exp_code == 1) chk("bad_size_latency", cyc - start_cyc, 1);
                if (exp_code == 2) chk("cts_timeout_latency", cyc - start_cyc, CTS_T + 1);
                if (stall_case)    chk("rx_timeout_latency", cyc - last_rx_cyc, RX_T + 1);
                hold_err  = (exp_code != 0);
                hold_code = 2'(exp_code);
            end else begin
                chk("error_hold", error, hold_err);
                chk("err_code_hold", err_code, hold_code);
            end
        end
    end

    // cts_dly < 0: CTS never asserted. rx_mode 1: rx_error at byte rx_n,
    // rx_mode 2: stall at byte rx_n. rst_after > 0: reset after that many tx_writes.
    task automatic run_cmd(input bit rw, input logic [6:0] id, input int size,
                           input logic [PW-1:0] wd, input int cts_dly,
                           input int rx_mode, input int rx_n, input int rst_after);
        bit valid, do_rx;
        valid = (size <= MAX);
        do_rx = valid && cts_dly >= 0 && !rw && size > 0;
        exp_tx.delete();
        tx_log = '0; n_txw = 0; n_txdone = 0; seen_done = 0;
        if (!valid) begin
            exp_code = 1;
        end else begin
            exp_rd = '0;
            if (cts_dly < 0) begin
                exp_code = 2;
            end else begin
                exp_code = 0;
                exp_tx.push_back({rw, id});
                exp_tx.push_back(8'(size));
                if (rw) begin
                    for (int k = 0; k < size; k++) exp_tx.push_back(wd[8*k +: 8]);
                end else begin
                    for (int k = 0; k < size; k++) begin
                        if (rx_mode != 0 && k == rx_n) begin
                            exp_code = 3;
                            break;
                        end
                        exp_rd[8*k +: 8] = rx_src[k];
                    end
                end
            end
        end
        stall_case   = do_rx && rx_mode == 2 && rx_n < size;
        done_pending = 1;

        @(posedge clk); #1;
        cmd_rw = rw; cmd_id = id; data_size = 8'(size); wr_data = wd;
        start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        if (valid) begin
            // command is latched: scramble the inputs and re-request while busy
            hold_err = 1'b0; hold_code = 2'd0;
            cmd_rw = ~rw; cmd_id = ~id; data_size = 8'($urandom); wr_data = ~wd;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end

        fork
            begin
                if (valid && cts_dly >= 0) begin
                    if (cts_dly >= 2) begin
                        // stray rx_done outside RECV_DATA must not land in rd_data
                        rx_byte = 8'hEE; rx_done = 1'b1;
                        @(posedge clk); #1;
                        rx_done = 1'b0;
                        repeat (cts_dly - 1) @(posedge clk);
                    end else begin
                        repeat (cts_dly) @(posedge clk);
                    end
                    #1 uart_cts = 1'b0;
                    repeat (2) @(posedge clk);
                    #1 uart_cts = 1'b1;
                end
            end
            begin
                if (do_rx) begin
                    for (int w = 0; w < 2000 && n_txdone < 2; w++) @(posedge clk);
                    #1;
                    for (int k = 0; k < size; k++) begin
                        repeat ($urandom_range(1, 6)) @(posedge clk);
                        #1;
                        if (rx_mode == 1 && k == rx_n) begin
                            rx_error = 1'b1; rx_done = 1'($urandom_range(0, 1)); rx_byte = 8'($urandom);
                            @(posedge clk); #1;
                            rx_error = 1'b0; rx_done = 1'b0;
                            break;
                        end
                        if (rx_mode == 2 && k == rx_n) break;
                        rx_byte = rx_src[k]; rx_done = 1'b1; last_rx_cyc = cyc;
                        @(posedge clk); #1;
                        rx_done = 1'b0;
                    end
                end
            end
            begin
                for (int w = 0; w < 4000; w++) begin
                    @(negedge clk);
                    if (seen_done || (rst_after > 0 && n_txw >= rst_after)) break;
                end
            end
        join

        if (rst_after > 0) begin
            @(posedge clk); #1;
            reset = 1'b1;
            exp_tx.delete();
            done_pending = 0; hold_err = 1'b0; hold_code = 2'd0; exp_rd = '0;
            @(posedge clk);
            @(negedge clk);
            chk("reset_rts", uart_rts, 1);
            chk("reset_busy", busy, 0);
            chk("reset_tx_write", tx_write, 0);
            @(posedge clk); #1;
            reset = 1'b0;
            repeat (20) @(posedge clk);
        end else begin
            chk("done_within_bound", seen_done, 1);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rts_init", uart_rts, 1);
        chk("reset_busy_init", busy, 0);
        chk("reset_done_init", done, 0);
        chk("reset_error_init", error, 0);
        chk("reset_code_init", err_code, 0);
        chk("reset_rd_data_init", rd_data, 0);
        chk("reset_tx_write_init", tx_write, 0);
        chk("reset_tx_byte_init", tx_byte, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // write 3 bytes
        run_cmd(1'b1, 7'h05, 3, PW'(24'h332211), 10, 0, 0, 0);
        chk("lit_write_seq", tx_log[39:0], 40'h8503112233);
        chk("lit_write_count", n_txw, 5);
        chk("lit_write_ok", err_code, 0);

        // read 2 bytes
        rx_src[0] = 8'hAB; rx_src[1] = 8'hCD;
        run_cmd(1'b0, 7'h02, 2, '0, 4, 0, 0, 0);
        chk("lit_read_cmd", tx_log[15:0], 16'h0202);
        chk("lit_read_count", n_txw, 2);
        chk("lit_read_data", rd_data[15:0], 16'hCDAB);

        // size 0 write, then oversize
        run_cmd(1'b1, 7'h00, 0, '0, 3, 0, 0, 0);
        chk("lit_size0_seq", tx_log[15:0], 16'h8000);
        chk("lit_size0_count", n_txw, 2);
        run_cmd(1'b1, 7'h09, MAX + 1, '0, 3, 0, 0, 0);
        chk("lit_bad_size_code", err_code, 1);
        chk("lit_bad_size_no_tx", n_txw, 0);
        chk("lit_bad_size_keeps_rd", rd_data[15:0], 16'h0000);

        // CTS never arrives
        run_cmd(1'b1, 7'h01, 2, '0, -1, 0, 0, 0);
        chk("lit_cts_code", err_code, 2);
        chk("lit_cts_no_tx", n_txw, 0);

        // read 4 with rx_error after the first byte, then with a stall
        rx_src[0] = 8'h5A; rx_src[1] = 8'h6B; rx_src[2] = 8'h7C; rx_src[3] = 8'h8D;
        run_cmd(1'b0, 7'h03, 4, '0, 2, 1, 1, 0);
        chk("lit_rx_err_code", err_code, 3);
        chk("lit_rx_err_data", rd_data[31:0], 32'h0000005A);
        run_cmd(1'b0, 7'h03, 4, '0, 2, 2, 1, 0);
        chk("lit_rx_stall_code", err_code, 3);
        chk("lit_rx_stall_data", rd_data[31:0], 32'h0000005A);

        // reset during SEND_DATA, then a normal command
        run_cmd(1'b1, 7'h11, 8, PW'(64'h0807060504030201), 3, 0, 0, 3);
        run_cmd(1'b1, 7'h12, 2, PW'(16'hBEEF), 5, 0, 0, 0);
        chk("lit_after_reset_seq", tx_log[31:0], 32'h9202EFBE);

        // randomized commands
        for (int t = 0; t < 24; t++) begin
            logic [PW-1:0] wd;
            bit rw;
            int sz, dly, mode, n;
            for (int k = 0; k < MAX; k++) begin
                wd[8*k +: 8] = 8'($urandom);
                rx_src[k]    = 8'($urandom);
            end
            rw   = 1'($urandom_range(0, 1));
            sz   = ($urandom_range(0, 9) == 0) ? MAX + 1 + int'($urandom_range(0, 2))
                                               : int'($urandom_range(0, MAX));
            dly  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, CTS_T - 5));
            mode = 0;
            n    = 0;
            if (!rw && sz >= 2 && $urandom_range(0, 3) == 0) begin
                mode = int'($urandom_range(1, 2));
                n    = int'($urandom_range(1, sz - 1));
            end
            run_cmd(rw, 7'($urandom), sz, wd, dly, mode, n, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/monitor_cmd_master.md
Name: monitor_cmd_master

Overview:
- Controller-side initiator for the monitor UART command protocol; the counterpart of the FPGA monitor slave.
- Runs the RTS/CTS handshake, then sends the command byte and the size byte.
- Then either sends N payload bytes (write) or collects N response bytes (read).
- Sits between a host/test sequencer and byte-level uart_tx/uart_rx instances in the same clk domain. Used for loopback testing of the monitor and for FPGA-to-FPGA control.

Parameters:
MAX_PAYLOAD_BYTES, 16, payload buffer depth in bytes (1..255)
CTS_TIMEOUT, 50000, clk cycles to wait for CTS before abort
RX_TIMEOUT, 500000, clk cycles allowed between received bytes before abort

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle request to run a command; ignored unless busy=0
cmd_rw  in  1  1 = write (master sends payload), 0 = read (monitor sends payload)
cmd_id  in  7  command id
data_size  in  8  payload byte count
wr_data  in  8*MAX_PAYLOAD_BYTES  write payload; byte k = wr_data[8k+:8]
rd_data  out  8*MAX_PAYLOAD_BYTES  read payload; byte k = rd_data[8k+:8]
busy  out  1  command in progress
done  out  1  one-cycle pulse at command end (success or error)
error  out  1  valid with done; 1 = aborted
err_code  out  2  0 none, 1 bad size, 2 CTS timeout, 3 RX timeout/rx_error
uart_rts  out  1  request to send, active-low
uart_cts  in  1  clear to send, active-low
tx_write  out  1  one-cycle pulse to load tx_byte into uart_tx
tx_byte  out  8  byte to transmit
tx_busy  in  1  uart_tx busy
tx_done  in  1  one-cycle pulse, uart_tx finished byte
rx_byte  in  8  last received byte
rx_done  in  1  one-cycle pulse, rx_byte valid
rx_error  in  1  framing/parity error pulse

Behaviour:
- Reset (synchronous, active-high): state=IDLE; uart_rts=1, tx_write=0, tx_byte=0, busy=0, done=0, error=0, err_code=0, rd_data=0; all counters 0. Applies mid-operation: rts returns high on the next edge and no further tx_write is issued.
- Command byte = {cmd_rw, cmd_id}. cmd_rw, cmd_id, data_size and wr_data are latched on an accepted start.
- IDLE: on start:
  - If data_size > MAX_PAYLOAD_BYTES: next cycle done=1, error=1, err_code=1; state stays IDLE; rts stays 1.
  - Otherwise: busy=1, rd_data cleared, uart_rts=0, go to REQ.
- REQ: count cycles while cts=1.
  - cts=0 sampled: go to SEND_CMD.
  - Count reaches CTS_TIMEOUT: abort with err_code=2.
- Byte send (SEND_CMD, SEND_SIZE, SEND_DATA): wait for tx_busy=0, then drive tx_byte and pulse tx_write for exactly one cycle. Then wait for tx_done; tx_done pulses outside a wait are ignored. Only one byte is outstanding at a time.
- SEND_CMD: sends the command byte, then goes to SEND_SIZE.
- SEND_SIZE: sends data_size. Next state:
  - size==0: FINISH.
  - cmd_rw=1: SEND_DATA.
  - cmd_rw=0: RECV_DATA.
  - Byte index is reset to 0 in all cases.
- SEND_DATA: sends wr_data byte[idx]; idx increments on tx_done. Go to FINISH after byte size-1.
- RECV_DATA: on rx_done, store rx_byte into rd_data byte[idx] and increment idx; go to FINISH after byte size-1.
  - Inter-byte counter resets on each rx_done; reaching RX_TIMEOUT aborts with err_code=3.
  - rx_error aborts with err_code=3; on the same cycle, rx_error wins over rx_done.
- rx_done outside RECV_DATA is ignored.
- cts is sampled only in REQ; later cts changes are ignored.
- FINISH: uart_rts=1, busy=0, done=1 for one cycle, error=0, err_code=0, then IDLE.
- Abort: same as FINISH but error=1 with the given err_code. rd_data keeps the bytes received so far.
- err_code and error hold their value until the next accepted start.
- start while busy is ignored. start on the done cycle is accepted if the state is IDLE.
- Index width is $clog2(MAX_PAYLOAD_BYTES+1); no wrap is possible because data_size is checked against MAX_PAYLOAD_BYTES.

Test Plan:
- Write: rw=1, id=0x05, size=3, wr_data bytes {0x11,0x22,0x33}; cts pulled low 10 cycles after rts falls -> tx sequence 0x85,0x03,0x11,0x22,0x33; one tx_write per byte; rts=1 and done=1, error=0 after the last tx_done.
- Read: rw=0, id=0x02, size=2; model returns 0xAB,0xCD -> tx 0x02,0x02 only; rd_data[15:0]=0xCDAB; done=1, error=0.
- size=0 write and size=MAX+1: first sends 0x80,0x00 then done; second produces no rts/tx activity, done=1, err_code=1.
- CTS never asserted -> done=1, err_code=2 exactly CTS_TIMEOUT cycles after rts falls; rts=1; no tx_write.
- Read size=4, rx_error after byte 1 (also a case where rx stalls past RX_TIMEOUT) -> err_code=3; rd_data holds byte 0 only.
- Reset asserted during SEND_DATA -> next edge: rts=1, busy=0, no further tx_write; a new start then completes normally.
